sort_arbiter: RTL and testbench

- Sequences and shares one insert_sort datapath (SIZE x 32-bit batch sorter) between two requesters.
- Grants round-robin, streams the winner's batch into the sorter, and waits for sorter done.
- Captures the SIZE sorted words and returns them with an owner tag.
- Includes a watchdog that resets a hung sorter.

---
 rtl/sort_arbiter_pkg.sv | 19 +
 rtl/sort_arbiter_rr.sv | 36 +++
 rtl/sort_arbiter.sv | 128 ++++++++++++
 tb/tb_sort_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_arbiter_pkg.sv
// Shared types for the two-requester batch-sort arbiter: FSM states,
// datapath word width and owner index width.
package sort_arbiter_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned OWNER_W = 1;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [OWNER_W-1:0] owner_t;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_LOAD,
        ST_SORT,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/sort_arbiter_rr.sv
// Two-way round-robin pick; last_owner only advances when the pick is
// committed, so an aborted batch still counts as that requester's turn.
module rr_arbiter2
    import sort_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       commit,
    output logic       any,
    output owner_t     pick
);

    owner_t last_owner;

    always_comb begin
        any = |req;
        if (req == 2'b11) begin
            pick = ~last_owner;
        end else if (req[1]) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= 1'b1;
        end else if (commit) begin
            last_owner <= pick;
        end
    end

endmodule

// File: rtl/sort_arbiter.sv
// Shares one external SIZE-word sorter between two requesters: round-robin
// grant, stream batch in, wait for done (with watchdog), drain tagged results.
module sort_arbiter
    import sort_arbiter_pkg::*;
#(
    parameter int unsigned SIZE    = 8,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [WORD_W-1:0] in_data0,
    input  logic [WORD_W-1:0] in_data1,
    output logic [1:0]        grant,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              out_tag,
    output logic              busy,
    output logic              error,
    output logic              srt_reset,
    output logic              srt_start,
    output logic [WORD_W-1:0] srt_data,
    input  logic              srt_done,
    input  logic [WORD_W-1:0] srt_out
);

    localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);
    localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wd;
    owner_t        owner;
    owner_t        pick;
    logic          any_req;
    logic          commit;

    assign commit = (state == ST_IDLE) && any_req;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .commit (commit),
        .any    (any_req),
        .pick   (pick)
    );

    always_comb begin
        grant = '0;
        if (state == ST_LOAD) begin
            grant[owner] = 1'b1;
        end
    end

    assign srt_data  = owner[0] ? in_data1 : in_data0;
    assign srt_start = (state == ST_LOAD) && (cnt == '0);
    assign srt_reset = (state == ST_RST);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RST;
            cnt       <= '0;
            wd        <= '0;
            owner     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_tag   <= 1'b0;
            error     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            error     <= 1'b0;
            case (state)
                ST_RST: begin
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (any_req) begin
                        owner <= pick;
                        cnt   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        wd    <= '0;
                        state <= ST_SORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SORT: begin
                    // done takes priority over a watchdog expiring on the same cycle
                    if (srt_done) begin
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else if (wd == WD_LAST) begin
                        error <= 1'b1;
                        state <= ST_RST;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    out_data  <= srt_out;
                    out_valid <= 1'b1;
                    out_tag   <= owner[0];
                    out_last  <= (cnt == LAST_IDX);
                    if (cnt == LAST_IDX) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_arbiter.sv
// Bench for sort_arbiter: behavioural sorter, two requester models and a
// scoreboard of expected tagged output words.
module tb_sort_arbiter;

    localparam int SIZE    = 8;
    localparam int TIMEOUT = 64;

    typedef logic [SIZE-1:0][31:0] batch_t;
    typedef struct {
        batch_t words;
        batch_t exp;
        bit     expect_out;
    } job_t;
    typedef struct {
        logic [31:0] data;
        logic        tag;
        logic        last;
    } sb_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] in_data0, in_data1;
    logic [1:0]  grant;
    logic [31:0] out_data;
    logic        out_valid, out_last, out_tag, busy, error;
    logic        srt_reset, srt_start;
    logic [31:0] srt_data;
    logic        srt_done = 1'b0;
    logic [31:0] srt_out  = '0;

    sort_arbiter #(.SIZE(SIZE), .TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .in_data0(in_data0), .in_data1(in_data1),
        .grant(grant), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_tag(out_tag), .busy(busy), .error(error),
        .srt_reset(srt_reset), .srt_start(srt_start), .srt_data(srt_data),
        .srt_done(srt_done), .srt_out(srt_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic batch_t mk(input int w0, input int w1, input int w2, input int w3,
                                  input int w4, input int w5, input int w6, input int w7);
        batch_t b;
        b[0] = w0; b[1] = w1; b[2] = w2; b[3] = w3;
        b[4] = w4; b[5] = w5; b[6] = w6; b[7] = w7;
        return b;
    endfunction

    function automatic batch_t sort_b(input batch_t b);
        batch_t s = b;
        logic [31:0] t;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE - 1 - i; j++)
                if ($signed(s[j]) > $signed(s[j+1])) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s;
    endfunction

    function automatic int inv_count(input batch_t b);
        int n = 0;
        for (int i = 0; i < SIZE; i++)
            for (int j = i + 1; j < SIZE; j++)
                if ($signed(b[i]) > $signed(b[j])) n++;
        return n;
    endfunction

    // Sorter model: done rises inversions+2 edges after the last word,
    // word k appears on srt_out at the (k+1)-th edge after done is sampled.
    batch_t sbuf, sorted_r;
    int     ld = 0, cd = 0, dcnt = SIZE;
    bit     hang = 1'b0;

    always @(posedge clk) begin
        if (srt_reset) begin
            srt_done <= 1'b0; ld <= 0; cd <= 0; dcnt <= SIZE;
        end else if (srt_start) begin
            sbuf[0] <= srt_data; ld <= 1; srt_done <= 1'b0; dcnt <= SIZE;
        end else if (ld > 0 && ld < SIZE) begin
            sbuf[ld] <= srt_data; ld <= ld + 1;
        end else if (ld == SIZE) begin
            sorted_r <= sort_b(sbuf); cd <= inv_count(sbuf); ld <= SIZE + 1;
        end else if (ld == SIZE + 1) begin
            if (cd > 0) cd <= cd - 1;
            else if (!hang) begin
                srt_done <= 1'b1; dcnt <= 0; ld <= 0;
            end
        end else if (srt_done && dcnt < SIZE) begin
            srt_out <= sorted_r[dcnt]; dcnt <= dcnt + 1;
        end
    end

    job_t pend0[$], pend1[$];
    sb_t  sb[$];
    int   owners[$];
    job_t cur;
    bit   active = 0;
    int   owner = 0, last_owner = 1, gcnt = 0;
    int   cyc = 0, req_cyc = 0, burst_start_cyc = 0, last_grant_cyc = 0;
    int   first_out_cyc = -1, out_words = 0;
    int   err_seen = 0, err_cyc = 0;
    logic err_srt_reset = 1'b0;

    task automatic tick();
        int   r;
        int   exp_owner;
        sb_t  e;
        logic [1:0] new_req;
        @(negedge clk);
        cyc++;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out_valid", 32'(out_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check_eq("out_data", out_data, e.data);
                check_eq("out_tag", 32'(out_tag), 32'(e.tag));
                check_eq("out_last", 32'(out_last), 32'(e.last));
                out_words++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
            end
        end else if (out_last) begin
            check_eq("last_without_valid", 32'(out_last), 32'(0));
        end
        if (error) begin
            err_seen++; err_cyc = cyc; err_srt_reset = srt_reset;
        end
        if (grant != 2'b00) begin
            check_eq("grant_onehot", 32'($countones(grant)), 32'(1));
            r = grant[1] ? 1 : 0;
            if (!active) begin
                if ((r == 1 && pend1.size() == 0) || (r == 0 && pend0.size() == 0)) begin
                    check_eq("spurious_grant", 32'(grant), 32'(0));
                end else begin
                    exp_owner = (pend0.size() != 0 && pend1.size() != 0) ? 1 - last_owner
                                                                         : (pend1.size() != 0 ? 1 : 0);
                    check_eq("grant_owner", 32'(r), 32'(exp_owner));
                    active = 1; owner = r; last_owner = r; gcnt = 0;
                    burst_start_cyc = cyc;
                    owners.push_back(r);
                    cur = (r == 1) ? pend1[0] : pend0[0];
                    if (cur.expect_out)
                        for (int k = 0; k < SIZE; k++)
                            sb.push_back('{data: cur.exp[k], tag: 1'(r), last: (k == SIZE - 1)});
                end
            end
            if (active) begin
                check_eq("grant_stable", 32'(grant), (owner == 1) ? 32'd2 : 32'd1);
                if (gcnt >= SIZE) begin
                    check_eq("grant_too_long", 32'(gcnt), 32'(SIZE - 1));
                end else begin
                    if (owner == 1) in_data1 = cur.words[gcnt];
                    else            in_data0 = cur.words[gcnt];
                    gcnt++;
                end
            end
        end else if (active) begin
            check_eq("grant_len", 32'(gcnt), 32'(SIZE));
            active = 0;
            last_grant_cyc = cyc - 1;
            if (owner == 1) void'(pend1.pop_front());
            else            void'(pend0.pop_front());
        end
        new_req = {pend1.size() != 0, pend0.size() != 0};
        if (req == 2'b00 && new_req != 2'b00) req_cyc = cyc;
        req = new_req;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(pend0.size() == 0 && pend1.size() == 0 && !active && sb.size() == 0 && busy == 1'b0)) begin
            if (n >= limit) begin
                check_eq("wait_idle_timeout", 32'(n), 32'(limit - 1));
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic push_job(input int r, input batch_t w, input batch_t x, input bit expect_out);
        job_t j;
        j.words = w; j.exp = x; j.expect_out = expect_out;
        if (r == 1) pend1.push_back(j);
        else        pend0.push_back(j);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        active = 0; last_owner = 1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        batch_t t1;
        int     base, n, inv1;
        reset = 1'b0; req = 2'b00; in_data0 = '0; in_data1 = '0;
        repeat (2) tick();
        check_eq("rst_grant", 32'(grant), 32'(0));
        check_eq("rst_out_data", out_data, 32'(0));
        check_eq("rst_out_valid", 32'(out_valid), 32'(0));
        check_eq("rst_out_last", 32'(out_last), 32'(0));
        check_eq("rst_out_tag", 32'(out_tag), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(1));
        check_eq("rst_error", 32'(error), 32'(0));
        check_eq("rst_srt_reset", 32'(srt_reset), 32'(1));
        check_eq("rst_srt_start", 32'(srt_start), 32'(0));
        reset = 1'b1;
        tick();
        check_eq("idle_busy", 32'(busy), 32'(0));
        check_eq("idle_srt_reset", 32'(srt_reset), 32'(0));

        // single batch from requester 0
        t1 = mk(5, 3, 9, -1, 7, 0, 2, 4);
        inv1 = inv_count(t1);
        push_job(0, t1, mk(-1, 0, 2, 3, 4, 5, 7, 9), 1);
        first_out_cyc = -1;
        tick();
        wait_idle(400);
        check_eq("grant_latency", 32'(burst_start_cyc - req_cyc), 32'(1));
        check_eq("out_latency", 32'(first_out_cyc - req_cyc), 32'(SIZE + (inv1 + 3) + 2));

        // tie from reset: 0, 1, 0
        do_reset();
        owners.delete();
        push_job(0, mk(1, 2, 3, 4, 5, 6, 7, 8), mk(1, 2, 3, 4, 5, 6, 7, 8), 1);
        push_job(1, mk(8, 7, 6, 5, 4, 3, 2, 1), mk(1, 2, 3, 4, 5, 6, 7, 8), 1);
        push_job(0, mk(100, -100, 0, 7, -7, 3, -3, 50), mk(-100, -7, -3, 0, 3, 7, 50, 100), 1);
        tick();
        wait_idle(1500);
        check_eq("tie_count", 32'(owners.size()), 32'(3));
        if (owners.size() == 3) begin
            check_eq("tie_owner0", 32'(owners[0]), 32'(0));
            check_eq("tie_owner1", 32'(owners[1]), 32'(1));
            check_eq("tie_owner2", 32'(owners[2]), 32'(0));
        end
        check_eq("no_error_worst_case", 32'(err_seen), 32'(0));

        // hung sorter: watchdog abort
        hang = 1'b1;
        push_job(0, mk(4, 3, 2, 1, 8, 7, 6, 5), '0, 0);
        n = 0;
        while (err_seen == 0 && n < 400) begin
            tick();
            n++;
        end
        check_eq("hang_error_seen", 32'(err_seen), 32'(1));
        check_eq("hang_error_timing", 32'(err_cyc - last_grant_cyc), 32'(TIMEOUT + 1));
        check_eq("hang_srt_reset", 32'(err_srt_reset), 32'(1));
        tick();
        check_eq("hang_error_pulse", 32'(error), 32'(0));
        check_eq("hang_then_idle", 32'(busy), 32'(0));
        check_eq("hang_srt_reset_drop", 32'(srt_reset), 32'(0));
        hang = 1'b0;

        // reset mid-drain after three words
        push_job(1, mk(40, -5, 12, 99, 3, -70, 8, 21), mk(-70, -5, 3, 8, 12, 21, 40, 99), 1);
        base = out_words;
        n = 0;
        while (out_words < base + 3 && n < 400) begin
            tick();
            n++;
        end
        check_eq("drain_words_before_reset", 32'(out_words - base), 32'(3));
        reset = 1'b0;
        #1;
        check_eq("abort_out_valid", 32'(out_valid), 32'(0));
        check_eq("abort_out_data", out_data, 32'(0));
        check_eq("abort_out_last", 32'(out_last), 32'(0));
        check_eq("abort_out_tag", 32'(out_tag), 32'(0));
        check_eq("abort_busy", 32'(busy), 32'(1));
        check_eq("abort_srt_reset", 32'(srt_reset), 32'(1));
        sb.delete();
        active = 0; last_owner = 1;
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // post-release batch from requester 1
        push_job(1, mk(10, 20, 30, 40, 50, 60, 70, 80), mk(10, 20, 30, 40, 50, 60, 70, 80), 1);
        tick();
        wait_idle(400);
        check_eq("total_errors_pulses", 32'(err_seen), 32'(1));
        check_eq("total_out_words", 32'(out_words), 32'(8 + 24 + 3 + 8));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
